// File: rtl/spmp_csr_file.sv
// SPMP architectural CSR state: spmpcfg, spmpaddr and spmpswitch.
// Accepts CSR read/write requests, applies WARL legalisation, exposes the
// packed register state to the permission checkers and provides a
// sequential bulk-clear engine plus an update pulse for cache flushing.
module spmp_csr_file #(
   parameter int NrEntries = 16,
   parameter int PLEN      = 56,
   parameter int XLEN      = 64,
   parameter int G         = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic                        req_we_i,
   input  logic [11:0]                 req_addr_i,
   input  logic [XLEN-1:0]             req_wdata_i,
   output logic                        rsp_valid_o,
   output logic [XLEN-1:0]             rsp_rdata_o,
   output logic                        rsp_err_o,
   input  logic                        clear_i,
   output logic                        busy_o,
   output logic                        update_o,
   output logic [NrEntries*8-1:0]      spmpcfg_o,
   output logic [NrEntries*(PLEN-2)-1:0] spmpaddr_o,
   output logic [63:0]                 spmpswitch_o
);

   localparam int AW = PLEN - 2;
   localparam logic [11:0] ADDR_END = 12'(12'h1B0 + NrEntries);
   localparam logic [3:0]  CFG_REGS = 4'((NrEntries + 7) / 8);
   localparam logic [63:0] SW_MASK  = (NrEntries >= 64) ? '1 : ((64'd1 << NrEntries) - 64'd1);
   localparam logic [6:0]  LAST_IDX = 7'(NrEntries - 1);

   typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;

   state_t                  state, state_next;
   logic [NrEntries*8-1:0]  cfg_q, cfg_post;
   logic [NrEntries*AW-1:0] addr_q, addr_post;
   logic [63:0]             sw_q, sw_post;
   logic [6:0]              clr_idx;
   logic                    clr_last;
   logic                    update_q;
   logic [XLEN-1:0]         rdata_q, rd_val;
   logic                    err_q;
   logic [3:0]              cfg_n;
   logic [11:0]             addr_off;
   logic                    sw_hit, cfg_hit, addr_hit, legal, accept;

   // WARL legalisation of one cfg byte: reserved bits cleared, NA4 kept out when G>=1
   function automatic logic [7:0] legal_cfg(input logic [7:0] wval, input logic [7:0] old);
      logic [1:0] a;
      a = wval[4:3];
      if (G >= 1 && a == 2'b10) a = old[4:3];
      return {wval[7], 2'b00, a, wval[2:0]};
   endfunction

   // Read-time view of an spmpaddr value; the stored bits are never altered
   function automatic logic [AW-1:0] mask_addr(input logic [AW-1:0] v, input logic [1:0] a);
      logic [AW-1:0] r;
      r = v;
      for (int b = 0; b < AW; b++) begin
         if (G >= 2 && a == 2'b11 && b <= G - 2) r[b] = 1'b1;
         else if (G >= 1 && !a[1] && b < G) r[b] = 1'b0;
      end
      return r;
   endfunction

   assign cfg_n    = req_addr_i[3:0];
   assign addr_off = req_addr_i - 12'h1B0;
   assign sw_hit   = (req_addr_i == 12'h170);
   assign cfg_hit  = (req_addr_i[11:4] == 8'h1A) && !cfg_n[0] && ({1'b0, cfg_n[3:1]} < CFG_REGS);
   assign addr_hit = (req_addr_i >= 12'h1B0) && (req_addr_i < ADDR_END);
   assign legal    = sw_hit | cfg_hit | addr_hit;
   assign clr_last = (clr_idx == LAST_IDX);
   assign accept   = req_ready_o && req_valid_i;

   // Post-write register images; equal to current state unless this is a hitting write
   always_comb begin
      cfg_post  = cfg_q;
      addr_post = addr_q;
      sw_post   = sw_q;
      for (int e = 0; e < NrEntries; e++) begin
         if (req_we_i && cfg_hit && 3'(e / 8) == cfg_n[3:1])
            cfg_post[8*e +: 8] = legal_cfg(req_wdata_i[8*(e%8) +: 8], cfg_q[8*e +: 8]);
         if (req_we_i && addr_hit && addr_off == 12'(e))
            addr_post[AW*e +: AW] = req_wdata_i[AW-1:0];
      end
      if (req_we_i && sw_hit) sw_post = req_wdata_i[63:0] & SW_MASK;
   end

   // Response data: the post-write (or current) value as software reads it
   always_comb begin
      rd_val = '0;
      if (sw_hit) rd_val[63:0] = sw_post;
      for (int e = 0; e < NrEntries; e++) begin
         if (cfg_hit && 3'(e / 8) == cfg_n[3:1])
            rd_val[8*(e%8) +: 8] = cfg_post[8*e +: 8];
         if (addr_hit && addr_off == 12'(e))
            rd_val[AW-1:0] = mask_addr(addr_post[AW*e +: AW], cfg_post[8*e+3 +: 2]);
      end
   end

   // FSM next state and handshake outputs; a clear request wins over a CSR request
   always_comb begin
      state_next  = state;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b0;
      case (state)
         IDLE: begin
            req_ready_o = !clear_i;
            if (clear_i)          state_next = CLEAR;
            else if (req_valid_i) state_next = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            state_next  = IDLE;
         end
         CLEAR: begin
            busy_o = 1'b1;
            if (clr_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Control state: FSM register, clear index, update pulse and response registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         clr_idx  <= '0;
         update_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_next;
         clr_idx  <= (state == CLEAR) ? clr_idx + 7'd1 : 7'd0;
         update_q <= (accept && req_we_i && legal) || (state == CLEAR && clr_last);
         if (accept) begin
            rdata_q <= rd_val;
            err_q   <= !legal;
         end
      end
   end

   // Register state: bulk clear walks one entry per cycle, otherwise commit accepted writes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cfg_q  <= '0;
         addr_q <= '0;
         sw_q   <= '0;
      end else if (state == CLEAR) begin
         for (int e = 0; e < NrEntries; e++) begin
            if (clr_idx == 7'(e)) begin
               cfg_q[8*e +: 8] <= 8'h00;
               sw_q[e]         <= 1'b0;
            end
         end
      end else if (accept && req_we_i) begin
         cfg_q  <= cfg_post;
         addr_q <= addr_post;
         sw_q   <= sw_post;
      end
   end

   assign rsp_rdata_o  = rdata_q;
   assign rsp_err_o    = err_q;
   assign update_o     = update_q;
   assign spmpcfg_o    = cfg_q;
   assign spmpaddr_o   = addr_q;
   assign spmpswitch_o = sw_q;

endmodule

// File: tb/tb_spmp_csr_file.sv
// Self-checking bench for spmp_csr_file: a G=0 instance plus a G=2 instance
// sharing the same stimulus; responses are checked through a scoreboard queue.
module tb_spmp_csr_file;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_we = 1'b0;
   logic [11:0]  req_addr = '0;
   logic [63:0]  req_wdata = '0;
   logic         clear = 1'b0;

   logic         ready, rsp_valid, err, busy, upd;
   logic [63:0]  rdata, sw_o;
   logic [127:0] cfg_o;
   logic [863:0] addr_o;

   logic         ready_g2, rsp_valid_g2, err_g2, busy_g2, upd_g2;
   logic [63:0]  rdata_g2, sw_g2;
   logic [127:0] cfg_g2;
   logic [863:0] addr_g2;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
      logic        upd;
      logic        g2;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   spmp_csr_file #(.NrEntries(16), .PLEN(56), .XLEN(64), .G(0)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rdata), .rsp_err_o(err),
      .clear_i(clear), .busy_o(busy), .update_o(upd),
      .spmpcfg_o(cfg_o), .spmpaddr_o(addr_o), .spmpswitch_o(sw_o)
   );

   spmp_csr_file #(.NrEntries(16), .PLEN(56), .XLEN(64), .G(2)) dut_g2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready_g2),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid_g2), .rsp_rdata_o(rdata_g2), .rsp_err_o(err_g2),
      .clear_i(clear), .busy_o(busy_g2), .update_o(upd_g2),
      .spmpcfg_o(cfg_g2), .spmpaddr_o(addr_g2), .spmpswitch_o(sw_g2)
   );

   task automatic check_rsp(input string name);
      exp_t        e;
      logic        got_v, got_e, got_u;
      logic [63:0] got_d;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: response arrived with empty scoreboard", name);
         return;
      end
      e     = sb.pop_front();
      got_v = e.g2 ? rsp_valid_g2 : rsp_valid;
      got_d = e.g2 ? rdata_g2 : rdata;
      got_e = e.g2 ? err_g2 : err;
      got_u = e.g2 ? upd_g2 : upd;
      if (got_v !== 1'b1) begin
         n_fail++;
         $display("FAIL %s rsp_valid: got %b expected 1", name, got_v);
      end
      n_checks++;
      if (got_d !== e.rdata) begin
         n_fail++;
         $display("FAIL %s rdata: got %h expected %h", name, got_d, e.rdata);
      end
      n_checks++;
      if (got_e !== e.err) begin
         n_fail++;
         $display("FAIL %s err: got %b expected %b", name, got_e, e.err);
      end
      n_checks++;
      if (got_u !== e.upd) begin
         n_fail++;
         $display("FAIL %s update: got %b expected %b", name, got_u, e.upd);
      end
   endtask

   task automatic do_req(input string name, input logic we, input logic [11:0] a,
                         input logic [63:0] wd, input logic [63:0] er,
                         input logic ee, input logic eu, input logic g2);
      int waitc;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      #1;
      waitc = 0;
      while (!ready && waitc < 20) begin
         @(negedge clk); #1;
         waitc++;
      end
      if (!ready) begin
         n_checks++; n_fail++;
         $display("FAIL %s: request not accepted, ready=%b expected 1", name, ready);
         req_valid = 1'b0;
         return;
      end
      sb.push_back('{rdata: er, err: ee, upd: eu, g2: g2});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_rsp(name);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ready, rsp_valid, busy, upd, err} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy/vld/busy/upd/err=%b expected 10000", {ready, rsp_valid, busy, upd, err});
      end
      n_checks++;
      if (rdata !== 64'd0) begin
         n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata);
      end
      n_checks++;
      if (cfg_o !== 128'd0 || addr_o !== 864'd0 || sw_o !== 64'd0) begin
         n_fail++; $display("FAIL reset_state: cfg %h sw %h expected all 0", cfg_o, sw_o);
      end
      n_checks++;
      if ({ready_g2, rsp_valid_g2, busy_g2, upd_g2, err_g2} !== 5'b10000 || rdata_g2 !== 64'd0 ||
          cfg_g2 !== 128'd0 || addr_g2 !== 864'd0 || sw_g2 !== 64'd0) begin
         n_fail++; $display("FAIL reset_g2: got cfg %h sw %h expected 0", cfg_g2, sw_g2);
      end
   endtask

   task automatic test_switch;
      do_req("sw_write", 1'b1, 12'h170, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      n_checks++;
      if (sw_o !== 64'hFFFF) begin
         n_fail++; $display("FAIL sw_out: got %h expected %h", sw_o, 64'hFFFF);
      end
      n_checks++;
      if (upd !== 1'b0) begin
         n_fail++; $display("FAIL sw_update_once: got %b expected 0", upd);
      end
      do_req("sw_read", 1'b0, 12'h170, 64'd0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_cfg;
      do_req("cfg_write0", 1'b1, 12'h1A0, 64'h9F60, 64'h9F00, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (cfg_o[15:0] !== 16'h9F00) begin
         n_fail++; $display("FAIL cfg_out01: got %h expected 9f00", cfg_o[15:0]);
      end
      do_req("cfg_write2", 1'b1, 12'h1A2, 64'hFF00_0000_0000_0001, 64'h9F00_0000_0000_0001, 1'b0, 1'b1, 1'b0);
      do_req("cfg_na4_g0", 1'b1, 12'h1A0, 64'h10, 64'h10, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (cfg_o !== 128'h9F00_0000_0000_0001_0000_0000_0000_0010) begin
         n_fail++; $display("FAIL cfg_out_all: got %h expected %h", cfg_o, 128'h9F00_0000_0000_0001_0000_0000_0000_0010);
      end
      n_checks++;
      if (cfg_g2[7:0] !== 8'h00) begin
         n_fail++; $display("FAIL cfg_na4_g2_kept: got %h expected 00", cfg_g2[7:0]);
      end
   endtask

   task automatic test_addr;
      do_req("addr_write3", 1'b1, 12'h1B3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h003F_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (addr_o[3*54 +: 54] !== 54'h3F_FFFF_FFFF_FFFF) begin
         n_fail++; $display("FAIL addr_out3: got %h expected %h", addr_o[3*54 +: 54], 54'h3F_FFFF_FFFF_FFFF);
      end
      do_req("addr_write15", 1'b1, 12'h1BF, 64'h1234, 64'h1234, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_errors;
      do_req("err_1a1", 1'b1, 12'h1A1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
      do_req("err_1a4", 1'b1, 12'h1A4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
      do_req("err_7ff", 1'b1, 12'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
      do_req("err_1c0", 1'b1, 12'h1C0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0);
      do_req("err_rd_1a6", 1'b0, 12'h1A6, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (cfg_o !== 128'h9F00_0000_0000_0001_0000_0000_0000_0010 || sw_o !== 64'hFFFF) begin
         n_fail++; $display("FAIL err_state_cfg_sw: got cfg %h sw %h", cfg_o, sw_o);
      end
      n_checks++;
      if (addr_o[3*54 +: 54] !== 54'h3F_FFFF_FFFF_FFFF || addr_o[15*54 +: 54] !== 54'h1234) begin
         n_fail++; $display("FAIL err_state_addr: got %h / %h", addr_o[3*54 +: 54], addr_o[15*54 +: 54]);
      end
      do_req("rd_cfg2", 1'b0, 12'h1A2, 64'd0, 64'h9F00_0000_0000_0001, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_g2_masking;
      do_req("g2_addr", 1'b1, 12'h1B0, 64'h1000, 64'h1000, 1'b0, 1'b1, 1'b1);
      do_req("g2_napot", 1'b1, 12'h1A0, 64'h18, 64'h18, 1'b0, 1'b1, 1'b1);
      do_req("g2_rd_napot", 1'b0, 12'h1B0, 64'd0, 64'h1001, 1'b0, 1'b0, 1'b1);
      do_req("g2_tor", 1'b1, 12'h1A0, 64'h08, 64'h08, 1'b0, 1'b1, 1'b1);
      do_req("g2_rd_tor", 1'b0, 12'h1B0, 64'd0, 64'h1000, 1'b0, 1'b0, 1'b1);
      do_req("g2_na4_keep", 1'b1, 12'h1A0, 64'h13, 64'h0B, 1'b0, 1'b1, 1'b1);
      do_req("g2_addr_low", 1'b1, 12'h1B0, 64'h1003, 64'h1000, 1'b0, 1'b1, 1'b1);
      n_checks++;
      if (addr_g2[53:0] !== 54'h1003) begin
         n_fail++; $display("FAIL g2_addr_stored: got %h expected 1003", addr_g2[53:0]);
      end
   endtask

   task automatic test_clear;
      logic [863:0] exp_addr;
      logic [63:0]  v;
      int busy_n, upd_n, bad_rdy, bad_vld, guard;
      exp_addr = '0;
      do_req("clr_prog_sw", 1'b1, 12'h170, 64'hFFFF, 64'hFFFF, 1'b0, 1'b1, 1'b0);
      do_req("clr_prog_cfg0", 1'b1, 12'h1A0, 64'h8787_8787_8787_8787, 64'h8787_8787_8787_8787, 1'b0, 1'b1, 1'b0);
      do_req("clr_prog_cfg2", 1'b1, 12'h1A2, 64'h8787_8787_8787_8787, 64'h8787_8787_8787_8787, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         v = 64'(i) * 64'h100 + 64'h55;
         exp_addr[54*i +: 54] = v[53:0];
         do_req("clr_prog_addr", 1'b1, 12'h1B0 + 12'(i), v, v, 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      clear = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h170; req_wdata = '0;
      #1;
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++; $display("FAIL clr_priority: ready got %b expected 0", ready);
      end
      @(posedge clk); #1;
      clear = 1'b0;
      busy_n = 0; upd_n = 0; bad_rdy = 0; bad_vld = 0; guard = 0;
      @(negedge clk);
      while (busy && guard < 40) begin
         busy_n++;
         if (ready) bad_rdy++;
         if (upd) upd_n++;
         if (rsp_valid) bad_vld++;
         @(negedge clk);
         guard++;
      end
      if (upd) upd_n++;
      n_checks++;
      if (busy_n != 16) begin
         n_fail++; $display("FAIL clr_busy_cycles: got %0d expected 16", busy_n);
      end
      n_checks++;
      if (bad_rdy != 0 || bad_vld != 0) begin
         n_fail++; $display("FAIL clr_stall: ready-cycles %0d rsp-cycles %0d expected 0", bad_rdy, bad_vld);
      end
      n_checks++;
      if (upd_n != 1) begin
         n_fail++; $display("FAIL clr_update: pulses %0d expected 1", upd_n);
      end
      n_checks++;
      if (cfg_o !== 128'd0 || sw_o !== 64'd0) begin
         n_fail++; $display("FAIL clr_cfg_sw: got cfg %h sw %h expected 0", cfg_o, sw_o);
      end
      n_checks++;
      if (addr_o !== exp_addr) begin
         n_fail++; $display("FAIL clr_addr_kept: entry1 got %h expected %h", addr_o[54 +: 54], exp_addr[54 +: 54]);
      end
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL clr_resume: ready got %b expected 1", ready);
      end else begin
         sb.push_back('{rdata: 64'd0, err: 1'b0, upd: 1'b0, g2: 1'b0});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check_rsp("clr_stalled_req");
   endtask

   task automatic test_rst_mid_clear;
      int cnt;
      do_req("rst_prog_sw", 1'b1, 12'h170, 64'hFFFF, 64'hFFFF, 1'b0, 1'b1, 1'b0);
      do_req("rst_prog_cfg", 1'b1, 12'h1A2, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      cnt = 0;
      @(negedge clk);
      while (busy && cnt < 4) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL rst_clr_busy5: busy got %b expected 1", busy);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({ready, rsp_valid, busy, upd, err} !== 5'b10000 || rdata !== 64'd0) begin
         n_fail++;
         $display("FAIL rst_clr_ctrl: got rdy/vld/busy/upd/err=%b rdata %h expected 10000/0", {ready, rsp_valid, busy, upd, err}, rdata);
      end
      n_checks++;
      if (cfg_o !== 128'd0 || addr_o !== 864'd0 || sw_o !== 64'd0) begin
         n_fail++; $display("FAIL rst_clr_state: got cfg %h sw %h expected 0", cfg_o, sw_o);
      end
      n_checks++;
      if ({ready_g2, rsp_valid_g2, busy_g2, upd_g2, err_g2} !== 5'b10000 || rdata_g2 !== 64'd0 ||
          cfg_g2 !== 128'd0 || addr_g2 !== 864'd0 || sw_g2 !== 64'd0) begin
         n_fail++; $display("FAIL rst_clr_g2: got cfg %h sw %h expected 0", cfg_g2, sw_g2);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || upd !== 1'b0) begin
         n_fail++; $display("FAIL rst_clr_after: busy %b rsp_valid %b update %b expected 0", busy, rsp_valid, upd);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_switch();
      test_cfg();
      test_addr();
      test_errors();
      test_g2_masking();
      test_clear();
      test_rst_mid_clear();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spmp_csr_file.md
Name: spmp_csr_file

Overview:
- Architectural SPMP register state: spmpcfg, spmpaddr and spmpswitch CSRs.
- Takes CSR read/write requests from the CSR regfile and applies WARL legalisation.
- Drives the packed spmpcfg, spmpaddr and spmpswitch vectors consumed by the SPMP permission checkers.
- Provides a sequential bulk-clear engine and an update pulse, so cached permission results can be flushed.

Parameters:
- NrEntries, 16, number of SPMP entries (1..64).
- PLEN, 56, physical address width; spmpaddr holds PLEN-2 bits.
- XLEN, 64, CSR data width; RV64 layout only.
- G, 0, SPMP granularity exponent; region granule is 2^(G+2) bytes.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  CSR request valid
- req_ready_o  out  1  request accepted this cycle
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  12  CSR address
- req_wdata_i  in  XLEN  write data
- rsp_valid_o  out  1  response valid, one cycle after acceptance
- rsp_rdata_o  out  XLEN  read data; for writes, the legalised post-write value
- rsp_err_o  out  1  illegal CSR address
- clear_i  in  1  start bulk clear (pulse)
- busy_o  out  1  bulk clear in progress
- update_o  out  1  one-cycle pulse after any state change
- spmpcfg_o  out  NrEntries*8  per-entry cfg bytes
- spmpaddr_o  out  NrEntries*(PLEN-2)  per-entry addresses
- spmpswitch_o  out  64  entry enables; bits >= NrEntries are 0

Behaviour:
- Reset: all cfg, addr and switch = 0; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; busy_o=0; update_o=0; FSM in IDLE.
- CSR map:
  - spmpswitch = 0x170.
  - spmpcfgN = 0x1A0+N. N must be even and N/2 < ceil(NrEntries/8). Register N covers entries 4N..4N+7, byte k -> entry 4N+k.
  - spmpaddrI = 0x1B0+I, I < NrEntries.
  - Any other address, including odd cfg addresses -> rsp_err_o=1, rdata=0, no state change.
- Cfg byte layout: bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bits6:5 reserved, bit7 S.
- Cfg WARL:
  - Reserved bits are written 0.
  - When G>=1, a write of A=NA4 keeps that entry's previous A field; the other fields still update.
  - All XWR/S combinations are legal and stored unchanged.
  - Bytes for entries >= NrEntries read 0 and ignore writes.
- spmpaddr write: stores wdata[PLEN-3:0]; upper bits ignored, read as 0.
- spmpaddr read masking, applied at read time only (stored bits unchanged):
  - G>=2 and entry A=NAPOT: bits G-2:0 read 1.
  - G>=1 and A in {OFF, TOR}: bits G-1:0 read 0.
- spmpswitch write: bits >= NrEntries are forced to 0.
- FSM states: IDLE, RESP, CLEAR.
  - IDLE, req_valid_i=1: accept (req_ready_o=1), commit any write at the clock edge, go to RESP.
  - RESP: rsp_valid_o=1 for exactly one cycle; req_ready_o=0; then IDLE. Maximum throughput is one request per 2 cycles.
  - IDLE, clear_i=1: go to CLEAR with index=0. clear_i takes priority over a simultaneous req_valid_i; that request is not accepted and must be held by the requester.
  - CLEAR: one entry per cycle: cfg[index]=0, switch[index]=0; spmpaddr is preserved.
  - CLEAR exit: after index=NrEntries-1 go to IDLE. Total NrEntries cycles with busy_o=1 and req_ready_o=0.
  - clear_i during CLEAR or RESP is ignored.
- update_o:
  - Pulses in the cycle after a legal write commits, even if the value is unchanged.
  - Pulses in the cycle after CLEAR completes.
  - Never pulses for reads or errored requests.
- Outputs spmp*_o reflect registered state; a write is visible in the cycle after acceptance.
- rst_i asserted in any state, including mid-CLEAR or RESP: next cycle everything is at reset values and no response is issued.

Test Plan:
- Write 0x170 = 0xFFFF_FFFF_FFFF_FFFF with NrEntries=16 -> read back 0x0000_0000_0000_FFFF; update_o pulses once; spmpswitch_o=0xFFFF.
- Write 0x1A0 = 0x0000_0000_0000_9F60 -> entry0 cfg=0x00 (0x60 has only reserved bits); entry1 cfg=0x9F (S=1, A=NAPOT, XWR=111); rsp_rdata=0x9F00.
- G=2: write spmpaddr0=0x1000, entry0 A=NAPOT -> read 0x1001; set A=TOR -> read 0x1000; A=NA4 write keeps TOR.
- Write 0x1A1, 0x1A4 (NrEntries=16) and 0x7FF -> rsp_err_o=1, rdata=0, no update_o, state unchanged.
- Program all 16 entries, assert clear_i together with req_valid_i -> request stalled; busy_o high exactly 16 cycles; then cfg=0, switch=0, addr unchanged; one update_o pulse; stalled request then served.
- Assert rst_i at CLEAR cycle 5 -> next cycle all outputs 0, busy_o=0, req_ready_o=1.
